// File: rtl/gpr_file_np_if.sv
// Port bundle for gpr_file_np: two combinational read ports, one write port,
// one link write port, a reservation port and the pending-register count.
interface gpr_file_np_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic              ra_busy;
  logic              rb_busy;
  logic              ba_mode;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              link_en;
  logic [DATA_W-1:0] link_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W:0]   busy_cnt;

  // No valid/ready handshake: every enable (wr_en, link_en, rsv_en) is a
  // single-cycle command taken at the rising edge on which it is high, and the
  // read ports answer combinationally with no back-pressure.
  modport slave (
    input  ra_addr, rb_addr, ba_mode,
    input  wr_en, wr_addr, wr_data,
    input  link_en, link_data,
    input  rsv_en, rsv_addr,
    output ra_data, rb_data, ra_busy, rb_busy, busy_cnt
  );

  modport master (
    output ra_addr, rb_addr, ba_mode,
    output wr_en, wr_addr, wr_data,
    output link_en, link_data,
    output rsv_en, rsv_addr,
    input  ra_data, rb_data, ra_busy, rb_busy, busy_cnt
  );
endinterface

// File: rtl/gpr_file_np.sv
// General-purpose register file with two read ports, a write port, a link
// write port, optional write-to-read forwarding and per-register pending bits.
module gpr_file_np #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 16,
  parameter int ADDR_W   = $clog2(NREGS),
  parameter int LINK_REG = NREGS - 1,
  parameter bit BYPASS   = 1'b1
) (
  input logic            clock,
  input logic            clear,
  gpr_file_np_if.slave   bus
);

  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_next;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_next;
  logic [DATA_W-1:0] ra_d;
  logic [DATA_W-1:0] rb_d;
  logic              set_one;
  logic              clr_wr;
  logic              clr_lk;

  // Link forwarding is checked first so it beats wr_data on the link register,
  // matching the store priority at the clock edge.
  always_comb begin
    ra_d = regs[bus.ra_addr];
    if (BYPASS) begin
      if (bus.link_en && bus.ra_addr == LINK_A) begin
        ra_d = bus.link_data;
      end else if (bus.wr_en && bus.wr_addr == bus.ra_addr) begin
        ra_d = bus.wr_data;
      end
    end
    if (bus.ba_mode && bus.ra_addr == '0) begin
      ra_d = '0;
    end
  end

  always_comb begin
    rb_d = regs[bus.rb_addr];
    if (BYPASS) begin
      if (bus.link_en && bus.rb_addr == LINK_A) begin
        rb_d = bus.link_data;
      end else if (bus.wr_en && bus.wr_addr == bus.rb_addr) begin
        rb_d = bus.wr_data;
      end
    end
  end

  // Writes clear pending bits, then a reservation re-sets its target so a
  // same-cycle reserve of a written register leaves it pending.
  always_comb begin
    busy_next = busy;
    if (bus.wr_en) begin
      busy_next[bus.wr_addr] = 1'b0;
    end
    if (bus.link_en) begin
      busy_next[LINK_A] = 1'b0;
    end
    if (bus.rsv_en) begin
      busy_next[bus.rsv_addr] = 1'b1;
    end
  end

  // Count deltas mirror busy_next; the link clear is skipped when the write
  // port already targets the link register so it is not counted twice.
  always_comb begin
    set_one = bus.rsv_en && !busy[bus.rsv_addr];
    clr_wr  = bus.wr_en && busy[bus.wr_addr] &&
              !(bus.rsv_en && bus.rsv_addr == bus.wr_addr);
    clr_lk  = bus.link_en && busy[LINK_A] &&
              !(bus.rsv_en && bus.rsv_addr == LINK_A) &&
              !(bus.wr_en && bus.wr_addr == LINK_A);
    cnt_next = cnt + (ADDR_W+1)'(set_one)
                   - (ADDR_W+1)'(clr_wr)
                   - (ADDR_W+1)'(clr_lk);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
      cnt  <= '0;
    end else begin
      if (bus.wr_en) begin
        regs[bus.wr_addr] <= bus.wr_data;
      end
      // Placed after the write port so link_data wins a shared target.
      if (bus.link_en) begin
        regs[LINK_A] <= bus.link_data;
      end
      busy <= busy_next;
      cnt  <= cnt_next;
    end
  end

  assign bus.ra_data  = ra_d;
  assign bus.rb_data  = rb_d;
  assign bus.ra_busy  = busy[bus.ra_addr];
  assign bus.rb_busy  = busy[bus.rb_addr];
  assign bus.busy_cnt = cnt;

endmodule
